// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sort-array controller
package sort_pkg;

  // Default packed sort item width (key/val/delta/pri/ptr)
  localparam int DEF_SORT_WIDTH = 32;

  // Bit range of the priority field inside a packed sort item
  localparam int PRI_POS_START = 8;
  localparam int PRI_POS_END   = 15;

  // Insert sequencer states; CLEAR empties the whole cell chain
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLACE = 3'd1,
    ST_WREN  = 3'd2,
    ST_ORDER = 3'd3,
    ST_CLEAR = 3'd4
  } sort_state_t;

endpackage

// File: rtl/sort_occ_counter.sv
// rtl/sort_occ_counter.sv - saturating occupancy counter with tail-eviction flag
module sort_occ_counter #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             evict
);

  assign full = (occupancy == CNT_W'(DEPTH));

  // An insert into a full chain pushes the lowest item off the tail
  assign evict = inc && full;

  // Count inserts up to DEPTH; a clear empties the chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (clr) begin
      occupancy <= '0;
    end else if (inc && !full) begin
      occupancy <= occupancy + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sort_array_ctrl.sv
// rtl/sort_array_ctrl.sv - place/write/order insert sequencer for the sort-cell chain (option: SORT_CTRL_STATS_EN)
module sort_array_ctrl #(
  parameter int SORT_WIDTH = sort_pkg::DEF_SORT_WIDTH,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [SORT_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [SORT_WIDTH-1:0] cell_datain,
  output logic                  cell_place_en,
  output logic                  cell_wren,
  output logic                  cell_order,
  output logic                  head_left_is_lower,
  output logic                  cell_clear,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  full,
  output logic                  evict,
  output logic                  busy
`ifdef SORT_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_inserts,
  output logic [31:0]           stat_evicts,
  output logic [31:0]           stat_flushes
`endif
);

  import sort_pkg::*;

  sort_state_t state;
  sort_state_t next_state;
  logic        flush_pending;
  logic        accept;
  logic        place_d;
  logic        wren_d;
  logic        order_d;
  logic        clear_d;

  // Cell 0 has no left neighbour, so it always treats the left side as lower
  assign head_left_is_lower = 1'b1;

  // A pending or same-cycle flush blocks new items so CLEAR can run first
  assign in_ready = (state == ST_IDLE) && !flush_pending && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: an insert always runs to ORDER before any clear
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (flush_pending) begin
          next_state = ST_CLEAR;
        end else if (accept) begin
          next_state = ST_PLACE;
        end
      end
      ST_PLACE: next_state = ST_WREN;
      ST_WREN:  next_state = ST_ORDER;
      ST_ORDER: next_state = flush_pending ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered pulses align with the state
  always_comb begin
    place_d = (next_state == ST_PLACE);
    wren_d  = (next_state == ST_WREN);
    order_d = (next_state == ST_ORDER);
    clear_d = (next_state == ST_CLEAR);
  end

  // Pulse registers; reset drops them without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_place_en <= 1'b0;
      cell_wren     <= 1'b0;
      cell_order    <= 1'b0;
      cell_clear    <= 1'b0;
    end else begin
      cell_place_en <= place_d;
      cell_wren     <= wren_d;
      cell_order    <= order_d;
      cell_clear    <= clear_d;
    end
  end

  // Remember a flush request until CLEAR is entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pending <= 1'b0;
    end else begin
      flush_pending <= flush || (flush_pending && (next_state != ST_CLEAR));
    end
  end

  // Broadcast item is held for the whole insert because cells sample it one cycle late
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_datain <= '0;
    end else if (accept) begin
      cell_datain <= in_data;
    end
  end

  sort_occ_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_occ (
    .clk       (clk),
    .reset     (reset),
    .inc       (cell_order),
    .clr       (cell_clear),
    .occupancy (occupancy),
    .full      (full),
    .evict     (evict)
  );

`ifdef SORT_CTRL_STATS_EN
  // Wrapping event counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_inserts <= '0;
      stat_evicts  <= '0;
      stat_flushes <= '0;
    end else begin
      if (cell_order) stat_inserts <= stat_inserts + 32'd1;
      if (evict)      stat_evicts  <= stat_evicts + 32'd1;
      if (cell_clear) stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sort_array_ctrl.sv
// tb/tb_sort_array_ctrl.sv - directed self-checking bench for sort_array_ctrl
module tb_sort_array_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        flush;
  logic [31:0] cell_datain;
  logic        cell_place_en;
  logic        cell_wren;
  logic        cell_order;
  logic        head_left_is_lower;
  logic        cell_clear;
  logic [4:0]  occupancy;
  logic        full;
  logic        evict;
  logic        busy;
`ifdef SORT_CTRL_STATS_EN
  logic [31:0] stat_inserts;
  logic [31:0] stat_evicts;
  logic [31:0] stat_flushes;
`endif

  int tests = 0;
  int fails = 0;

  sort_array_ctrl #(
    .SORT_WIDTH (32),
    .DEPTH      (16),
    .CNT_W      (5)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .flush              (flush),
    .cell_datain        (cell_datain),
    .cell_place_en      (cell_place_en),
    .cell_wren          (cell_wren),
    .cell_order         (cell_order),
    .head_left_is_lower (head_left_is_lower),
    .cell_clear         (cell_clear),
    .occupancy          (occupancy),
    .full               (full),
    .evict              (evict),
    .busy               (busy)
`ifdef SORT_CTRL_STATS_EN
    ,
    .stat_inserts       (stat_inserts),
    .stat_evicts        (stat_evicts),
    .stat_flushes       (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One full insert starting in IDLE; keep leaves in_valid high for a back-to-back follower
  task automatic insert(input logic [31:0] d, input logic keep, input logic exp_ev,
                        input logic [4:0] exp_occ);
    check("ins_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    if (!keep) in_valid = 1'b0;
    check("place_en", cell_place_en, 1);
    check("place_wren", cell_wren, 0);
    check("place_ready", in_ready, 0);
    check("place_datain", cell_datain, d);
    tick();
    check("wren", cell_wren, 1);
    check("wren_place", cell_place_en, 0);
    check("wren_datain", cell_datain, d);
    tick();
    check("order", cell_order, 1);
    check("order_evict", evict, exp_ev);
    check("order_datain", cell_datain, d);
    tick();
    check("idle_order", cell_order, 0);
    check("idle_busy", busy, 0);
    check("idle_evict", evict, 0);
    check("idle_occ", occupancy, exp_occ);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_occ", occupancy, 0);
    check("rst_datain", cell_datain, 0);
    check("rst_pulses", {cell_place_en, cell_wren, cell_order, cell_clear, evict}, 0);
    check("rst_head", head_left_is_lower, 1);
    check("rst_full", full, 0);
    check("rst_ready", in_ready, 1);

    // Single insert of 1.0
    insert(32'h3F800000, 1'b0, 1'b0, 5'd1);
    check("single_ready", in_ready, 1);

    // Back-to-back 2.0, 1.0, 0.5 with in_valid held
    do_reset();
    insert(32'h40000000, 1'b1, 1'b0, 5'd1);
    insert(32'h3F800000, 1'b1, 1'b0, 5'd2);
    insert(32'h3F000000, 1'b0, 1'b0, 5'd3);
    check("b2b_full", full, 0);

    // DEPTH+1 inserts: only the 17th evicts
    do_reset();
    for (int i = 0; i < 17; i++) begin
      insert(32'h40000000, (i < 16), (i == 16), (i < 16) ? 5'(i + 1) : 5'd16);
    end
    check("sat_occ", occupancy, 16);
    check("sat_full", full, 1);

    // Flush pulsed during WREN: ORDER completes, then CLEAR
    in_valid = 1'b1;
    in_data  = 32'h3FC00000;
    tick();
    in_valid = 1'b0;
    check("fl_place", cell_place_en, 1);
    tick();
    check("fl_wren", cell_wren, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_order", cell_order, 1);
    check("fl_order_evict", evict, 1);
    check("fl_order_clear", cell_clear, 0);
    tick();
    check("fl_clear", cell_clear, 1);
    check("fl_clear_order", cell_order, 0);
    check("fl_clear_ready", in_ready, 0);
    check("fl_clear_busy", busy, 1);
    tick();
    check("fl_done_clear", cell_clear, 0);
    check("fl_done_occ", occupancy, 0);
    check("fl_done_full", full, 0);
    check("fl_done_ready", in_ready, 1);
    check("fl_done_datain", cell_datain, 32'h3FC00000);

    // Flush and in_valid together in IDLE: clear first, item afterwards
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h3F000000;
    #1;
    check("fv_ready_now", in_ready, 0);
    tick();
    flush = 1'b0;
    check("fv_pend_ready", in_ready, 0);
    check("fv_pend_place", cell_place_en, 0);
    check("fv_pend_busy", busy, 0);
    tick();
    check("fv_clear", cell_clear, 1);
    check("fv_clear_ready", in_ready, 0);
    tick();
    check("fv_idle_ready", in_ready, 1);
    check("fv_idle_datain", cell_datain, 32'h3FC00000);
    tick();
    in_valid = 1'b0;
    check("fv_place", cell_place_en, 1);
    check("fv_datain", cell_datain, 32'h3F000000);
    tick();
    check("fv_wren", cell_wren, 1);
    tick();
    check("fv_order", cell_order, 1);
    tick();
    check("fv_occ", occupancy, 1);

    // Asynchronous reset in the middle of ORDER
    in_valid = 1'b1;
    in_data  = 32'h40400000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ar_order", cell_order, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_order_drop", cell_order, 0);
    check("ar_busy", busy, 0);
    check("ar_occ", occupancy, 0);
    check("ar_datain", cell_datain, 0);
`ifdef SORT_CTRL_STATS_EN
    check("ar_stat_ins", stat_inserts, 0);
    check("ar_stat_ev", stat_evicts, 0);
    check("ar_stat_fl", stat_flushes, 0);
`endif
    tick();
    reset = 1'b0;
    check("ar_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sort_array_ctrl.md
Name: sort_array_ctrl

Overview:
- Sequences a linear array of floating-point priority sort cells through their three-phase insert protocol: place (compare enable), write (latch compare result), order (shift/insert).
- Accepts new items on a valid/ready interface and broadcasts each item to all cells.
- Tracks occupancy, flags evictions and issues array clears.
- Sits between the upstream update engine and the sort-cell chain in the priority-queue datapath.

Parameters:
- SORT_WIDTH, 32, width of a sort item (key/val/delta/pri/ptr packed).
- DEPTH, 16, number of sort cells in the chain.
- CNT_W, 5, occupancy counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream item valid
- in_data  in  SORT_WIDTH  upstream item
- in_ready  out  1  controller can accept an item this cycle
- flush  in  1  request to empty the array (level, sampled each cycle)
- cell_datain  out  SORT_WIDTH  broadcast item to every cell's datain; also the prev_data of cell 0
- cell_place_en  out  1  compare-enable pulse to all cells
- cell_wren  out  1  latch-compare pulse to all cells
- cell_order  out  1  shift/insert pulse to all cells
- head_left_is_lower  out  1  left_is_lower input of cell 0; constant 1
- cell_clear  out  1  one-cycle synchronous clear to all cells
- occupancy  out  CNT_W  valid items held, 0..DEPTH
- full  out  1  occupancy == DEPTH
- evict  out  1  one-cycle pulse: an insert occurred while full, so the lowest item fell off the tail
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-high): FSM=IDLE; occupancy=0; cell_datain=0; all pulse outputs 0; head_left_is_lower=1; pending-flush flag=0.
- FSM states and transitions:
  - IDLE→PLACE when in_valid && in_ready && !flush_pending.
  - PLACE→WREN unconditionally.
  - WREN→ORDER unconditionally.
  - ORDER→IDLE, or →CLEAR if flush_pending.
  - IDLE→CLEAR when flush_pending (takes priority over in_valid).
  - CLEAR→IDLE.
- Output decode is registered, so each pulse is high for exactly the one cycle the FSM sits in its state:
  - PLACE: cell_place_en=1.
  - WREN: cell_wren=1.
  - ORDER: cell_order=1.
  - CLEAR: cell_clear=1.
- Data capture and hold:
  - cell_datain is loaded from in_data on the accept edge (IDLE→PLACE).
  - It is held unchanged through PLACE, WREN and ORDER, because cells sample datain one cycle late for their stored copy.
  - Outside an insert it keeps its last value.
- in_ready = (state==IDLE) && !flush_pending && !flush.
  - Insert throughput is 1 item per 4 cycles (IDLE, PLACE, WREN, ORDER).
  - Accept-to-order latency is 3 cycles.
- flush handling:
  - Any cycle flush=1 sets flush_pending.
  - flush_pending is cleared on entry to CLEAR.
  - flush asserted mid-insert never aborts the insert; CLEAR follows ORDER.
- Occupancy:
  - Increments at the ORDER cycle if occupancy<DEPTH.
  - Saturates at DEPTH; at that point evict=1 in the ORDER cycle.
  - Set to 0 in the CLEAR cycle.
  - full is combinational from occupancy.
- Boundary cases:
  - in_valid with flush in the same IDLE cycle: flush wins, item not accepted (in_ready=0).
  - in_valid held with in_ready=0: item not consumed; upstream must hold in_data stable.
  - Reset asserted mid-sequence: immediate return to IDLE; pulses drop asynchronously; occupancy=0. The array must be reset by the same signal.
- Arithmetic: occupancy is unsigned and never wraps; DEPTH+1 is never reached.

Optional Feature:
- Macro SORT_CTRL_STATS_EN.
- When defined, adds three outputs, each a 32-bit wrapping counter cleared only by reset:
  - stat_inserts: counts ORDER cycles.
  - stat_evicts: counts evict pulses.
  - stat_flushes: counts CLEAR cycles.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sort_pkg holds:
  - the FSM state enum (IDLE, PLACE, WREN, ORDER, CLEAR);
  - SORT_WIDTH default;
  - priority field position constants PRI_POS_START/PRI_POS_END.
- One natural sub-module: sort_occ_counter, holding the saturating occupancy counter and evict generation.

Test Plan:
- Reset, then single insert of 32'h3F800000 (1.0): in_ready drops the next cycle; place_en, wren, order pulse on cycles 1, 2, 3 after accept; cell_datain holds 3F800000 throughout; occupancy=1; busy low in cycle 4.
- Back-to-back in_valid with items 1.0, 2.0, 0.5 held continuously: accepts spaced exactly 4 cycles; occupancy ends at 3; with the array attached, the cell contents read 2.0, 1.0, 0.5.
- DEPTH+1 inserts of 32'h40000000: evict is high only in the ORDER cycle of the 17th insert; occupancy stays 16; full=1.
- flush pulsed during WREN of an insert: ORDER still occurs, then CLEAR the next cycle with cell_clear=1; occupancy=0; in_ready returns the cycle after.
- flush and in_valid both high in IDLE: CLEAR taken; in_ready=0; item accepted on the following IDLE cycle.
- Async reset asserted mid-ORDER: cell_order falls without waiting for a clock edge; state=IDLE; occupancy=0; with SORT_CTRL_STATS_EN defined, all stat counters read 0.
